// File: rtl/systolic_pkg.sv
// ============================================================================
// systolic_pkg : shared types and helpers for the systolic array feeder
// Revision     : 1.0
// ============================================================================
`default_nettype none

package systolic_pkg;

    localparam int DW_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } feeder_state_t;

    // Number of cycles needed to push a fully skewed SIZE-wide wavefront.
    function automatic int stream_len(input int size);
        return 2 * size - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_feed_lane.sv
// ============================================================================
// systolic_feed_lane : one skewed edge lane; emits vec[t-LANE] in its window
// Revision           : 1.0
// ============================================================================
`default_nettype none

module systolic_feed_lane
    import systolic_pkg::*;
#(
    parameter int SIZE = 4,
    parameter int DW   = DW_DEFAULT,
    parameter int LANE = 0,
    parameter int TW   = $clog2(2 * SIZE)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fire,
    input  logic [TW-1:0]            t_next,
    input  logic [SIZE-1:0][DW-1:0]  vec,
    output logic [DW-1:0]            data,
    output logic                     valid
);

    localparam int            KW   = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [TW-1:0] C_LO = TW'(LANE);
    localparam logic [TW-1:0] C_HI = TW'(LANE + SIZE);

    logic          w_in_win;
    logic [KW-1:0] w_idx;

    // t_next is the stream index of the cycle these registers will present.
    assign w_in_win = fire && (t_next >= C_LO) && (t_next < C_HI);
    assign w_idx    = KW'(t_next - C_LO);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= w_in_win;
            data  <= w_in_win ? vec[w_idx] : '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/systolic_feeder.sv
// ============================================================================
// systolic_feeder : buffers one A/B operand pair and streams it, skewed,
//                   into the systolic MAC array edge; pulses done at drain end
// Revision        : 1.0
// ============================================================================
`default_nettype none

module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int SIZE    = 4,
    parameter int DW      = DW_DEFAULT,
    parameter int MAC_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [SIZE-1:0][DW-1:0]  load_a,
    input  logic [SIZE-1:0][DW-1:0]  load_b,
    input  logic                     start,
    output logic [SIZE-1:0][DW-1:0]  a_in_o,
    output logic [SIZE-1:0][DW-1:0]  b_in_o,
    output logic [SIZE-1:0]          valid_a_o,
    output logic [SIZE-1:0]          valid_b_o,
    output logic                     acc_clear,
    output logic                     busy,
    output logic                     done
);

    localparam int            TW         = $clog2(2 * SIZE);
    localparam int            KW         = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int            DRW        = $clog2(SIZE * MAC_LAT + 1);
    localparam logic [TW-1:0] C_T_LAST   = TW'(stream_len(SIZE) - 1);
    localparam logic [TW-1:0] C_CNT_LAST = TW'(SIZE - 1);
    localparam logic [DRW-1:0] C_DRAIN_LAST = DRW'(SIZE * MAC_LAT - 1);

    feeder_state_t                    r_state;
    logic [TW-1:0]                    r_t;
    logic [TW-1:0]                    r_load_cnt;
    logic [DRW-1:0]                   r_drain;
    logic                             r_loaded;
    logic [SIZE-1:0][SIZE-1:0][DW-1:0] r_buf_a;
    logic [SIZE-1:0][SIZE-1:0][DW-1:0] r_buf_b;

    logic          w_accept;
    logic          w_fire;
    logic [TW-1:0] w_t_next;

    assign w_accept = load_valid && load_ready;

    // Lanes register their outputs, so they are fed the index of the next cycle.
    assign w_fire   = (r_state == CLEAR) || ((r_state == STREAM) && (r_t != C_T_LAST));
    assign w_t_next = (r_state == CLEAR) ? '0 : (r_t + TW'(1));

    // Row i of A and column j of B are each stored as a k-indexed vector.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < SIZE; i++) begin
                r_buf_a[i][KW'(r_load_cnt)] <= load_a[i];
                r_buf_b[i][KW'(r_load_cnt)] <= load_b[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_t        <= '0;
            r_drain    <= '0;
            r_load_cnt <= '0;
            r_loaded   <= 1'b0;
            load_ready <= 1'b0;
            acc_clear  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && r_loaded) begin
                        r_state    <= CLEAR;
                        acc_clear  <= 1'b1;
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
                    end else if (w_accept) begin
                        r_load_cnt <= r_load_cnt + TW'(1);
                        if (r_load_cnt == C_CNT_LAST) begin
                            r_loaded   <= 1'b1;
                            load_ready <= 1'b0;
                        end else begin
                            load_ready <= 1'b1;
                        end
                    end else begin
                        load_ready <= !r_loaded;
                    end
                end
                CLEAR: begin
                    acc_clear <= 1'b0;
                    r_t       <= '0;
                    r_state   <= STREAM;
                end
                STREAM: begin
                    if (r_t == C_T_LAST) begin
                        r_drain <= '0;
                        r_state <= DRAIN;
                    end else begin
                        r_t <= r_t + TW'(1);
                    end
                end
                DRAIN: begin
                    if (r_drain == C_DRAIN_LAST) begin
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_drain <= r_drain + DRW'(1);
                    end
                end
                DONE: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    r_loaded   <= 1'b0;
                    r_load_cnt <= '0;
                    load_ready <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < SIZE; g++) begin : g_lane
        systolic_feed_lane #(
            .SIZE (SIZE),
            .DW   (DW),
            .LANE (g),
            .TW   (TW)
        ) u_lane_a (
            .clk    (clk),
            .reset  (reset),
            .fire   (w_fire),
            .t_next (w_t_next),
            .vec    (r_buf_a[g]),
            .data   (a_in_o[g]),
            .valid  (valid_a_o[g])
        );

        systolic_feed_lane #(
            .SIZE (SIZE),
            .DW   (DW),
            .LANE (g),
            .TW   (TW)
        ) u_lane_b (
            .clk    (clk),
            .reset  (reset),
            .fire   (w_fire),
            .t_next (w_t_next),
            .vec    (r_buf_b[g]),
            .data   (b_in_o[g]),
            .valid  (valid_b_o[g])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_systolic_feeder.sv
// ============================================================================
// tb_systolic_feeder : scoreboard bench for systolic_feeder with an array model
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_systolic_feeder;

    localparam int SIZE = 4;
    localparam int DW   = 8;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    load_valid = 1'b0;
    logic                    start = 1'b0;
    logic [SIZE-1:0][DW-1:0] load_a = '0;
    logic [SIZE-1:0][DW-1:0] load_b = '0;
    logic                    load_ready;
    logic [SIZE-1:0][DW-1:0] a_in_o;
    logic [SIZE-1:0][DW-1:0] b_in_o;
    logic [SIZE-1:0]         valid_a_o;
    logic [SIZE-1:0]         valid_b_o;
    logic                    acc_clear;
    logic                    busy;
    logic                    done;

    typedef struct packed {
        logic [SIZE-1:0]         va;
        logic [SIZE-1:0]         vb;
        logic [SIZE-1:0][DW-1:0] a;
        logic [SIZE-1:0][DW-1:0] b;
        logic                    clr;
        logic                    dn;
    } rec_t;

    rec_t q[$];
    int   ma[SIZE][SIZE];
    int   mb[SIZE][SIZE];
    int   exp_c[SIZE][SIZE];
    int   acc[SIZE][SIZE];
    logic [DW-1:0] pa[SIZE][SIZE];
    logic [DW-1:0] pb[SIZE][SIZE];
    logic pva[SIZE][SIZE];
    logic pvb[SIZE][SIZE];
    int   n_checks = 0;
    int   n_pass   = 0;

    systolic_feeder #(.SIZE(SIZE), .DW(DW), .MAC_LAT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_a     (load_a),
        .load_b     (load_b),
        .start      (start),
        .a_in_o     (a_in_o),
        .b_in_o     (b_in_o),
        .valid_a_o  (valid_a_o),
        .valid_b_o  (valid_b_o),
        .acc_clear  (acc_clear),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Output-stationary array: A flows right, B flows down, one hop per cycle.
    always @(posedge clk) begin : array_model
        logic [DW-1:0] ain, bin;
        logic          vain, vbin;
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                if (j == 0) begin ain = a_in_o[i]; vain = valid_a_o[i]; end
                else        begin ain = pa[i][j-1]; vain = pva[i][j-1]; end
                if (i == 0) begin bin = b_in_o[j]; vbin = valid_b_o[j]; end
                else        begin bin = pb[i-1][j]; vbin = pvb[i-1][j]; end
                pa[i][j]  <= ain;
                pb[i][j]  <= bin;
                pva[i][j] <= vain;
                pvb[i][j] <= vbin;
                if (acc_clear)
                    acc[i][j] <= 0;
                else if (vain === 1'b1 && vbin === 1'b1)
                    acc[i][j] <= acc[i][j] + int'(ain) * int'(bin);
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    // Monitor: every busy cycle must match the next scoreboard entry.
    always @(negedge clk) begin : monitor
        rec_t act, ex;
        if (reset && busy) begin
            act = {valid_a_o, valid_b_o, a_in_o, b_in_o, acc_clear, done};
            if (q.size() == 0) begin
                chk("unexpected_busy", 128'(busy), 128'(0));
            end else begin
                ex = q.pop_front();
                chk("edge_cycle", 128'(act), 128'(ex));
                if (ex.dn) begin
                    for (int i = 0; i < SIZE; i++)
                        for (int j = 0; j < SIZE; j++)
                            chk($sformatf("out[%0d][%0d]", i, j), 128'(acc[i][j]), 128'(exp_c[i][j]));
                end
            end
        end
    end

    task automatic push_run();
        rec_t r;
        int   v;
        r = '0; r.clr = 1'b1; q.push_back(r);
        for (int t = 0; t < 2 * SIZE - 1; t++) begin
            r = '0;
            for (int i = 0; i < SIZE; i++) begin
                if (i <= t && t < i + SIZE) begin
                    r.va[i] = 1'b1; v = ma[i][t-i]; r.a[i] = v[DW-1:0];
                    r.vb[i] = 1'b1; v = mb[t-i][i]; r.b[i] = v[DW-1:0];
                end
            end
            q.push_back(r);
        end
        for (int d = 0; d < SIZE; d++) begin r = '0; q.push_back(r); end
        r = '0; r.dn = 1'b1; q.push_back(r);
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                exp_c[i][j] = 0;
                for (int k = 0; k < SIZE; k++) exp_c[i][j] += ma[i][k] * mb[k][j];
            end
    endtask

    task automatic load_beat(input int k, input logic with_start);
        int v;
        chk("load_ready_before_beat", 128'(load_ready), 128'(1));
        for (int i = 0; i < SIZE; i++) begin
            v = ma[i][k]; load_a[i] = v[DW-1:0];
            v = mb[k][i]; load_b[i] = v[DW-1:0];
        end
        load_valid = 1'b1;
        start      = with_start;
        @(posedge clk); #1;
        load_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic load_all();
        for (int k = 0; k < SIZE; k++) load_beat(k, 1'b0);
    endtask

    task automatic do_run(input logic hold_start, input logic hold_load);
        logic got;
        push_run();
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        load_valid = hold_load;
        load_a     = '1;
        load_b     = '1;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (hold_load) chk("load_ready_while_busy", 128'(load_ready), 128'(0));
            if (done) begin got = 1'b1; load_valid = 1'b0; end
        end
        load_valid = 1'b0;
        chk("done_seen", 128'(got), 128'(1));
        @(posedge clk); #1;
        chk("busy_after_done", 128'(busy), 128'(0));
        chk("scoreboard_drained", 128'(q.size()), 128'(0));
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        chk("single_run_only", 128'(busy), 128'(0));
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        chk("reset_outputs", 128'({load_ready, a_in_o, b_in_o, valid_a_o, valid_b_o,
                                    acc_clear, busy, done}), 128'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        chk("load_ready_after_reset", 128'(load_ready), 128'(1));

        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                ma[i][j] = 10 * i + j;
                mb[i][j] = 10 * i + j;
            end

        // Start with a partial load, then start together with the final beat.
        for (int k = 0; k < SIZE - 1; k++) load_beat(k, 1'b0);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("start_partial_ignored", 128'({busy, acc_clear}), 128'(0));
        load_beat(SIZE - 1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("start_with_last_beat_ignored", 128'(busy), 128'(0));
        chk("load_ready_when_full", 128'(load_ready), 128'(0));

        do_run(1'b1, 1'b1);

        // Asynchronous reset in the middle of the stream.
        load_all();
        push_run();
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (acc_clear) break;
        end
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        chk("reset_kills_valids", 128'({valid_a_o, valid_b_o, busy, a_in_o, b_in_o}), 128'(0));
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("load_ready_after_midrun_reset", 128'(load_ready), 128'(1));
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("start_after_reset_ignored", 128'({busy, acc_clear}), 128'(0));

        // End-to-end through the array model: B = I, then B = 2I.
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                ma[i][j] = SIZE * i + j + 1;
                mb[i][j] = (i == j) ? 1 : 0;
            end
        load_all();
        do_run(1'b0, 1'b0);
        for (int i = 0; i < SIZE; i++) mb[i][i] = 2;
        load_all();
        do_run(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
